// File: rtl/three_state_gates_pkg.sv
// Shared defaults and helpers for the three_state_gates tri-state driver.
// No state here; used by the top and the enable-edge counter.
package three_state_gates_pkg;

  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned DEF_CNT_W = 8;

  function automatic logic rise_det(input logic prev, input logic cur);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/three_state_gates_edge_cnt.sv
// Rising-edge detector on the effective enable feeding a saturating counter.
// Latency: count updates on the iClk edge that samples the rise; no backpressure.
module three_state_gates_edge_cnt
  import three_state_gates_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEE,
  output logic [CNT_W-1:0] oCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             prev_ee_q, prev_ee_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // prev_ee resets low so an enable already high at reset release counts once
  always_comb begin
    prev_ee_d = iEE;
    cnt_d     = cnt_q;
    if (rise_det(prev_ee_q, iEE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      prev_ee_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      prev_ee_q <= prev_ee_d;
      cnt_q     <= cnt_d;
    end
  end

  assign oCnt = cnt_q;

endmodule

// File: rtl/three_state_gates.sv
// Tri-state bus driver with a clocked status side-band (driving flag, enable-edge count).
// Latency: 0 cycles (REGISTERED=0) or 1 cycle (REGISTERED=1); no backpressure, never resolves contention.
module three_state_gates
  import three_state_gates_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter bit          REGISTERED = 1'b0,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iA,
  input  logic             iEna,
  output tri   [WIDTH-1:0] oTri,
  output logic             oDriving,
  output logic [CNT_W-1:0] oEnaEdges
);

  logic [WIDTH-1:0] drv_a;
  logic             drv_en;

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] a_q, a_d;
      logic             ena_q, ena_d;

      always_comb begin
        a_d   = iA;
        ena_d = iEna;
      end

      // Async clear releases the bus immediately, without waiting for a clock
      always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
          a_q   <= '0;
          ena_q <= 1'b0;
        end else begin
          a_q   <= a_d;
          ena_q <= ena_d;
        end
      end

      assign drv_a  = a_q;
      assign drv_en = ena_q;
    end else begin : g_comb
      assign drv_a  = iA;
      assign drv_en = iEna;
    end
  endgenerate

  assign oTri = drv_en ? drv_a : {WIDTH{1'bz}};

  logic driving_q, driving_d;

  always_comb begin
    driving_d = drv_en;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      driving_q <= 1'b0;
    end else begin
      driving_q <= driving_d;
    end
  end

  assign oDriving = driving_q;

  three_state_gates_edge_cnt #(
    .CNT_W(CNT_W)
  ) u_edge_cnt (
    .iClk(iClk),
    .iRst(iRst),
    .iEE (drv_en),
    .oCnt(oEnaEdges)
  );

endmodule

// File: tb/tb_three_state_gates.sv
// Directed and randomized checks of three_state_gates in combinational, registered and saturating builds.
`define CHKZ(TAG, SIG, ZV) begin n_cmp++; assert (SIG === ZV) else begin n_bad++; $error("FAIL %s: got %0h want Z", TAG, SIG); end end

module tb_three_state_gates;

  int n_cmp = 0;
  int n_bad = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // combinational, WIDTH=1
  logic       rst1, a1, en1, drv1;
  tri   [0:0] bus1;
  logic [7:0] cnt1;
  // combinational, WIDTH=8, shared with a second driver
  logic       rst8, en8, drv8, drv2_en;
  logic [7:0] a8, drv2_val, cnt8;
  tri   [7:0] bus8;
  // registered, WIDTH=8
  logic       rstr, enr, drvr;
  logic [7:0] ar, cntr;
  tri   [7:0] busr;
  // combinational, CNT_W=2
  logic       rsts, as_, ens, drvs;
  tri   [0:0] buss;
  logic [1:0] cnts;

  assign bus8 = drv2_en ? drv2_val : 8'hzz;

  three_state_gates #(.WIDTH(1), .REGISTERED(1'b0), .CNT_W(8)) u_c1 (
    .iClk(clk), .iRst(rst1), .iA(a1), .iEna(en1),
    .oTri(bus1), .oDriving(drv1), .oEnaEdges(cnt1));

  three_state_gates #(.WIDTH(8), .REGISTERED(1'b0), .CNT_W(8)) u_c8 (
    .iClk(clk), .iRst(rst8), .iA(a8), .iEna(en8),
    .oTri(bus8), .oDriving(drv8), .oEnaEdges(cnt8));

  three_state_gates #(.WIDTH(8), .REGISTERED(1'b1), .CNT_W(8)) u_r (
    .iClk(clk), .iRst(rstr), .iA(ar), .iEna(enr),
    .oTri(busr), .oDriving(drvr), .oEnaEdges(cntr));

  three_state_gates #(.WIDTH(1), .REGISTERED(1'b0), .CNT_W(2)) u_s (
    .iClk(clk), .iRst(rsts), .iA(as_), .iEna(ens),
    .oTri(buss), .oDriving(drvs), .oEnaEdges(cnts));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference state for the registered build: what was captured, and EE history
  logic       m_ena, m_prev;
  logic [7:0] m_a;
  int         m_rises;

  initial begin
    rst1 = 1'b1; rst8 = 1'b1; rstr = 1'b1; rsts = 1'b1;
    a1 = 1'b0; en1 = 1'b0; a8 = 8'h00; en8 = 1'b0;
    ar = 8'h00; enr = 1'b0; as_ = 1'b0; ens = 1'b0;
    drv2_en = 1'b0; drv2_val = 8'h00;
    #2;
    `CHKZ("rst_busr", busr, 8'hzz)
    chk("rst_drvr", 32'(drvr), 32'd0);
    chk("rst_cntr", 32'(cntr), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_cnts", 32'(cnts), 32'd0);

    // combinational WIDTH=1 data path
    rst1 = 1'b0; a1 = 1'b0; en1 = 1'b1; #1;
    chk("c1_drive0", 32'(bus1), 32'd0);
    en1 = 1'b0; #1;
    `CHKZ("c1_rel", bus1, 1'bz)
    a1 = 1'b1; #1;
    `CHKZ("c1_rel_achg", bus1, 1'bz)
    en1 = 1'b1; #1;
    chk("c1_drive1", 32'(bus1), 32'd1);
    rst1 = 1'b1; #1;
    chk("c1_rst_noeff", 32'(bus1), 32'd1);
    rst1 = 1'b0;
    en1 = 1'b0; #1;
    `CHKZ("c1_rel2", bus1, 1'bz)
    a1 = 1'b0; #1;
    a1 = 1'b1; #1;
    `CHKZ("c1_rel3", bus1, 1'bz)

    // enable-edge counter on the WIDTH=1 build
    tick();
    rst1 = 1'b1; #1; rst1 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      en1 = 1'b1; tick();
      chk("c1_cnt", 32'(cnt1), 32'(i));
      chk("c1_drv_hi", 32'(drv1), 32'd1);
      en1 = 1'b0; tick();
      chk("c1_drv_lo", 32'(drv1), 32'd0);
    end
    en1 = 1'b1; tick();
    chk("c1_cnt6", 32'(cnt1), 32'd6);
    repeat (10) tick();
    chk("c1_hold_cnt", 32'(cnt1), 32'd6);
    chk("c1_hold_drv", 32'(drv1), 32'd1);

    // WIDTH=8 with a second driver on the released net
    rst8 = 1'b0; a8 = 8'hA5; en8 = 1'b1; #1;
    chk("c8_drive", 32'(bus8), 32'h0000_00A5);
    en8 = 1'b0; #1;
    `CHKZ("c8_rel", bus8, 8'hzz)
    drv2_val = 8'h3C; drv2_en = 1'b1; #1;
    chk("c8_other", 32'(bus8), 32'h0000_003C);
    drv2_en = 1'b0; #1;

    // registered build: one-cycle latency and async release
    rstr = 1'b0; enr = 1'b0; ar = 8'h00;
    tick();
    `CHKZ("r_idle", busr, 8'hzz)
    #3; ar = 8'h5A; enr = 1'b1; #1;
    `CHKZ("r_midcyc", busr, 8'hzz)
    tick();
    chk("r_lat1", 32'(busr), 32'h0000_005A);
    chk("r_drv_late", 32'(drvr), 32'd0);
    tick();
    chk("r_drv", 32'(drvr), 32'd1);
    chk("r_cnt", 32'(cntr), 32'd1);
    #2; rstr = 1'b1; #1;
    `CHKZ("r_async_rst", busr, 8'hzz)
    chk("r_rst_drv", 32'(drvr), 32'd0);
    chk("r_rst_cnt", 32'(cntr), 32'd0);
    tick();
    `CHKZ("r_rst_held", busr, 8'hzz)
    rstr = 1'b0;

    // randomized run on the registered build against a history-based model
    enr = 1'b0; rstr = 1'b1; #1; rstr = 1'b0;
    m_ena = 1'b0; m_prev = 1'b0; m_a = 8'h00; m_rises = 0;
    for (int k = 0; k < 300; k++) begin
      ar  = 8'($urandom);
      enr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        rstr = 1'b1; #1;
        m_ena = 1'b0; m_prev = 1'b0; m_a = 8'h00; m_rises = 0;
        `CHKZ("rnd_rst_bus", busr, 8'hzz)
        chk("rnd_rst_cnt", 32'(cntr), 32'd0);
        rstr = 1'b0;
      end
      tick();
      if (m_ena && !m_prev) m_rises++;
      m_prev = m_ena;
      m_ena  = enr;
      m_a    = ar;
      if (m_ena) chk("rnd_bus", 32'(busr), 32'(m_a));
      else `CHKZ("rnd_busz", busr, 8'hzz)
      chk("rnd_drv", 32'(drvr), 32'(m_prev));
      chk("rnd_cnt", 32'(cntr), (m_rises > 255) ? 32'd255 : 32'(m_rises));
    end

    // saturation with CNT_W=2
    rsts = 1'b0; ens = 1'b0;
    tick();
    for (int i = 1; i <= 6; i++) begin
      ens = 1'b1; tick();
      chk("s_cnt", 32'(cnts), (i > 3) ? 32'd3 : 32'(i));
      ens = 1'b0; tick();
    end
    rsts = 1'b1; #1;
    chk("s_rst", 32'(cnts), 32'd0);
    ens = 1'b1;
    tick();
    chk("s_rst_held", 32'(cnts), 32'd0);
    rsts = 1'b0; #2;
    tick();
    chk("s_rel_cnt", 32'(cnts), 32'd1);
    chk("s_rel_drv", 32'(drvs), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
